// File: rtl/safecrack_pkg.sv
// Shared definitions for the safecrack button front end and the lock FSM.
// Contents:
//   NUM_BTN        number of physical push-buttons
//   BTN_W          width of a code word handed to the lock FSM
//   btn_gesture_t  states of the press/release gesture tracker
package safecrack_pkg;

  localparam int NUM_BTN = 4;
  localparam int BTN_W   = 4;

  typedef enum logic [1:0] {
    G_IDLE,
    G_HELD,
    G_EMIT,
    G_DISCARD
  } btn_gesture_t;

endpackage

// File: rtl/safecrack_btn_conditioner_if.sv
// Signal bundle between the button pins / lock FSM and the button conditioner.
// Signals:
//   btn_raw     raw asynchronous button pins
//   enable      1 = gestures accepted, 0 = gestures discarded
//   btn_level   debounced button level, pressed = 1
//   code        OR of all buttons seen during the last accepted gesture
//   code_valid  one-cycle strobe qualifying code
//   busy        gesture in progress or being discarded
// Modports:
//   master  environment side (drives pins and enable, consumes codes)
//   slave   conditioner side
interface safecrack_btn_conditioner_if;
  import safecrack_pkg::*;

  logic [NUM_BTN-1:0] btn_raw;
  logic               enable;
  logic [NUM_BTN-1:0] btn_level;
  logic [BTN_W-1:0]   code;
  logic               code_valid;
  logic               busy;

  modport master (
    output btn_raw,
    output enable,
    input  btn_level,
    input  code,
    input  code_valid,
    input  busy
  );

  modport slave (
    input  btn_raw,
    input  enable,
    output btn_level,
    output code,
    output code_valid,
    output busy
  );

endinterface

// File: rtl/safecrack_debounce.sv
// One-bit synchroniser and debouncer.
// A two-flop synchroniser brings the (already normalised, pressed = 1) pin
// into the clock domain; the stable output only follows the synchronised bit
// after it has differed for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   din    normalised asynchronous button bit
//   dout   debounced stable level
module safecrack_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter runs only while the synchronised bit disagrees with the
  // accepted level, so any agreement (a bounce back) restarts the wait.
  // Acceptance clears the counter, so it never needs to saturate.
  always_comb begin
    sync1_d  = din;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/safecrack_btn_conditioner.sv
// Button front end for the safecrack lock FSM.
// Normalises the raw pins to pressed = 1, debounces each bit, and turns every
// complete press-and-release gesture into a single code word with a one-cycle
// strobe. Buttons chorded during one gesture are OR-merged into that code.
// Gestures that start, or are still held, while enable is low are swallowed.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    slave side of safecrack_btn_conditioner_if
//          (btn_raw, enable in; btn_level, code, code_valid, busy out)
module safecrack_btn_conditioner
  import safecrack_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW_IN   = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  safecrack_btn_conditioner_if.slave  bus
);

  logic [NUM_BTN-1:0] btn_norm;
  logic [NUM_BTN-1:0] stable;

  btn_gesture_t       state_q;
  logic [BTN_W-1:0]   acc_q;
  logic [BTN_W-1:0]   code_q;
  logic               code_valid_q;
  logic               busy_q;

  assign btn_norm = (ACTIVE_LOW_IN != 0) ? ~bus.btn_raw : bus.btn_raw;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    safecrack_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (btn_norm[i]),
      .dout (stable[i])
    );
  end

  // Gesture tracker. The strobe and busy are registered alongside the state,
  // so code_valid is high exactly while the FSM sits in G_EMIT. Dropping
  // enable is checked before release so a release coinciding with a disable
  // is discarded rather than emitted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= G_IDLE;
      acc_q        <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      code_valid_q <= 1'b0;
      case (state_q)
        G_IDLE: begin
          if (stable != '0) begin
            busy_q <= 1'b1;
            if (bus.enable) begin
              state_q <= G_HELD;
              acc_q   <= stable;
            end else begin
              state_q <= G_DISCARD;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        G_HELD: begin
          acc_q <= acc_q | stable;
          if (!bus.enable) begin
            state_q <= G_DISCARD;
          end else if (stable == '0) begin
            state_q      <= G_EMIT;
            code_q       <= acc_q;
            code_valid_q <= 1'b1;
          end
        end
        G_EMIT: begin
          state_q <= G_IDLE;
          busy_q  <= 1'b0;
        end
        G_DISCARD: begin
          if (stable == '0) begin
            state_q <= G_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= G_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.btn_level  = stable;
  assign bus.code       = code_q;
  assign bus.code_valid = code_valid_q;
  assign bus.busy       = busy_q;

endmodule
